// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multi-cycle RV32I controller and the
// datapath/shared memory it sequences.
interface multicycle_control_unit_if;
    // Datapath and memory status seen by the controller
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        mem_ready;

    // Controller outputs steering the datapath and memory
    logic        mem_req;
    logic        Mem_Write;
    logic        Adr_src;
    logic        IR_write;
    logic        PC_write;
    logic        Reg_write;
    logic [2:0]  Imm_src;
    logic [1:0]  ALU_src_A;
    logic [1:0]  ALU_src_B;
    logic [3:0]  ALU_control;
    logic [1:0]  Result_src;
    logic        trap;
    logic [1:0]  trap_cause;

    // Controller side
    modport master (
        input  instr, zero, lt, ltu, mem_ready,
        output mem_req, Mem_Write, Adr_src, IR_write, PC_write, Reg_write,
               Imm_src, ALU_src_A, ALU_src_B, ALU_control, Result_src,
               trap, trap_cause
    );

    // Datapath / memory side
    modport slave (
        output instr, zero, lt, ltu, mem_ready,
        input  mem_req, Mem_Write, Adr_src, IR_write, PC_write, Reg_write,
               Imm_src, ALU_src_A, ALU_src_B, ALU_control, Result_src,
               trap, trap_cause
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller. Sequences each instruction over several
// cycles on a shared instruction/data memory, with a mem_req/mem_ready
// wait-state handshake, a bounded memory timeout and a sticky trap state.
module multicycle_control_unit #(
    parameter int TIMEOUT    = 15,   // max wait cycles before trapping (1..255)
    parameter bit TIMEOUT_EN = 1'b1  // 0: wait for memory indefinitely
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    // FSM state encoding
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADR   = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_LINK      = 4'd12;
    localparam logic [3:0] S_LUI       = 4'd13;
    localparam logic [3:0] S_TRAP      = 4'd14;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [7:0] wait_cnt;
    logic [1:0] cause_q;
    logic [1:0] cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt_bit;
    logic       mem_state;
    logic       timed_out;
    logic       branch_bad;
    logic       taken;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign alt_bit = bus.instr[30];

    // Instruction fields that only the datapath consumes
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // States that hold a memory request open and are therefore timed
    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);

    // A completing access (mem_ready high) always beats the limit
    assign timed_out = TIMEOUT_EN && mem_state && !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

    // funct3 010/011 are not defined for conditional branches
    assign branch_bad = (funct3 == 3'b010) || (funct3 == 3'b011);

    // ALU op shared by R- and I-type execution; alt selects sub/sra
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch condition evaluated from the ALU flags
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = !bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next-state selection and the cause recorded on entry to TRAP
    always_comb begin
        next_state = state;
        cause_d    = CAUSE_NONE;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    default: begin
                        next_state = S_TRAP;
                        cause_d    = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADR: next_state = bus.instr[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB, S_ALU_WB, S_LINK, S_LUI: next_state = S_FETCH;
            S_EXEC_R, S_EXEC_I:                next_state = S_ALU_WB;
            S_BRANCH: begin
                if (branch_bad) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_ILLEGAL;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_JAL, S_JALR: next_state = S_LINK;
            S_TRAP:        next_state = S_TRAP;
            default:       next_state = S_FETCH;  // unused encodings recover
        endcase
    end

    // State, wait counter and sticky trap cause
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before this clock edge.
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= 8'd0;
            end else if (mem_state && !bus.mem_ready && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if ((next_state == S_TRAP) && (state != S_TRAP)) begin
                cause_q <= cause_d;
            end
        end
    end

    // Moore control decode (plus completion/branch qualified writes), forced low in reset
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.Mem_Write   = 1'b0;
        bus.Adr_src     = 1'b0;
        bus.IR_write    = 1'b0;
        bus.PC_write    = 1'b0;
        bus.Reg_write   = 1'b0;
        bus.Imm_src     = 3'b000;
        bus.ALU_src_A   = 2'b00;
        bus.ALU_src_B   = 2'b00;
        bus.ALU_control = ALU_ADD;
        bus.Result_src  = 2'b00;
        bus.trap        = 1'b0;
        bus.trap_cause  = CAUSE_NONE;
        if (!reset) begin
            bus.trap_cause = cause_q;
            case (state)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.ALU_src_B  = 2'b10;
                    bus.Result_src = 2'b10;
                    bus.IR_write   = bus.mem_ready;
                    bus.PC_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALU_src_A = 2'b01;
                    bus.ALU_src_B = 2'b01;
                    bus.Imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                end
                S_MEM_ADR: begin
                    bus.ALU_src_A = 2'b10;
                    bus.ALU_src_B = 2'b01;
                    bus.Imm_src   = bus.instr[5] ? 3'b001 : 3'b000;
                end
                S_MEM_READ: begin
                    bus.mem_req = 1'b1;
                    bus.Adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    bus.Result_src = 2'b01;
                    bus.Reg_write  = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.mem_req   = 1'b1;
                    bus.Mem_Write = 1'b1;
                    bus.Adr_src   = 1'b1;
                end
                S_EXEC_R: begin
                    bus.ALU_src_A   = 2'b10;
                    bus.ALU_control = alu_decode(funct3, alt_bit);
                end
                S_EXEC_I: begin
                    bus.ALU_src_A   = 2'b10;
                    bus.ALU_src_B   = 2'b01;
                    bus.ALU_control = alu_decode(funct3, alt_bit && (funct3 == 3'b101));
                end
                S_ALU_WB: bus.Reg_write = 1'b1;
                S_BRANCH: begin
                    bus.ALU_src_A   = 2'b10;
                    bus.ALU_control = ALU_SUB;
                    bus.PC_write    = taken && !branch_bad;
                end
                S_JAL: bus.PC_write = 1'b1;
                S_JALR: begin
                    bus.ALU_src_A  = 2'b10;
                    bus.ALU_src_B  = 2'b01;
                    bus.Result_src = 2'b10;
                    bus.PC_write   = 1'b1;
                end
                S_LINK: begin
                    bus.ALU_src_A  = 2'b01;
                    bus.ALU_src_B  = 2'b10;
                    bus.Result_src = 2'b10;
                    bus.Reg_write  = 1'b1;
                end
                S_LUI: begin
                    bus.Imm_src    = 3'b100;
                    bus.Result_src = 2'b11;
                    bus.Reg_write  = 1'b1;
                end
                S_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the stimulus process expands
// each instruction into its expected per-cycle control words, and a monitor
// compares them against the DUT on every falling edge.
module tb_multicycle_control_unit;

    localparam int TIMEOUT = 15;

    // Field order of the printed hex words: mem_req, mem_write, adr_src,
    // ir_write, pc_write, reg_write, imm_src, src_a, src_b, alu, res, trap, cause
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [2:0] imm_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu;
        logic [1:0] res;
        logic       trap;
        logic [1:0] cause;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    multicycle_control_unit_if bus();

    multicycle_control_unit #(.TIMEOUT(TIMEOUT), .TIMEOUT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ctrl_t exp_q[$];
    string name_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cycle_no = 0;

    logic [31:0] cur_instr;
    logic        cur_z, cur_l, cur_lu;
    bit          pulse_pending = 0;

    function automatic ctrl_t sample();
        ctrl_t s;
        s.mem_req   = bus.mem_req;
        s.mem_write = bus.Mem_Write;
        s.adr_src   = bus.Adr_src;
        s.ir_write  = bus.IR_write;
        s.pc_write  = bus.PC_write;
        s.reg_write = bus.Reg_write;
        s.imm_src   = bus.Imm_src;
        s.src_a     = bus.ALU_src_A;
        s.src_b     = bus.ALU_src_B;
        s.alu       = bus.ALU_control;
        s.res       = bus.Result_src;
        s.trap      = bus.trap;
        s.cause     = bus.trap_cause;
        return s;
    endfunction

    // Monitor: whenever a cycle's expectation is pending, compare it
    initial begin
        ctrl_t e, g;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                g = sample();
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): got %h want %h", n, cycle_no, g, e);
                end
            end
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic ctrl_t mk(input int mreq, input int mw, input int adr, input int irw,
                                 input int pcw, input int rw, input int imm, input int a,
                                 input int b, input int alu, input int res);
        ctrl_t e;
        e.mem_req   = 1'(mreq);
        e.mem_write = 1'(mw);
        e.adr_src   = 1'(adr);
        e.ir_write  = 1'(irw);
        e.pc_write  = 1'(pcw);
        e.reg_write = 1'(rw);
        e.imm_src   = 3'(imm);
        e.src_a     = 2'(a);
        e.src_b     = 2'(b);
        e.alu       = 4'(alu);
        e.res       = 2'(res);
        e.trap      = 1'b0;
        e.cause     = 2'b00;
        return e;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU code by funct3 (add sll slt sltu xor srl or and), alt -> sub/sra
    function automatic int exp_alu(input logic [2:0] f3, input logic alt);
        int base [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        if (alt && f3 == 3'd0) return 1;
        if (alt && f3 == 3'd5) return 9;
        return base[f3];
    endfunction

    // One clock cycle: drive inputs just after the edge, queue the expectation
    task automatic cyc(input string name, input ctrl_t e, input logic mr, input logic rst);
        @(posedge clk);
        #1;
        cycle_no++;
        if (pulse_pending) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
            pulse_pending = 0;
        end
        reset         = rst;
        bus.mem_ready = mr;
        bus.instr     = cur_instr;
        bus.zero      = cur_z;
        bus.lt        = cur_lu ? cur_l : cur_l;
        bus.ltu       = cur_lu;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // A memory access that waits 'waits' cycles; the access may wait at most
    // TIMEOUT cycles, one more waiting cycle than that ends in a trap.
    task automatic mem_phase(input string name, input ctrl_t waiting, input ctrl_t done,
                             input int waits, output bit to);
        to = 0;
        for (int k = 0; k <= waits; k++) begin
            if (k == waits) begin
                cyc(name, done, 1'b1, 1'b0);
            end else begin
                cyc(name, waiting, 1'b0, 1'b0);
                if (k == TIMEOUT) begin
                    to = 1;
                    break;
                end
            end
        end
    endtask

    // Sticky trap for a few cycles, then a held reset returns to FETCH
    task automatic trap_phase(input logic [1:0] cause);
        ctrl_t t;
        t = '0;
        t.trap  = 1'b1;
        t.cause = cause;
        for (int k = 0; k < 3; k++) cyc("trap", t, rnd1(), 1'b0);
        cyc("trap_reset", '0, rnd1(), 1'b1);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input logic l, input logic lu);
        bit         to;
        logic [6:0] op;
        logic [2:0] f3;
        logic       flag;
        op = ins[6:0];
        f3 = ins[14:12];
        cur_z = z;
        cur_l = l;
        cur_lu = lu;
        cur_instr = $urandom;
        mem_phase("fetch", mk(1,0,0,0,0,0,0,0,2,0,2), mk(1,0,0,1,1,0,0,0,2,0,2), fw, to);
        if (to) begin
            trap_phase(2'b10);
            return;
        end
        cur_instr = ins;
        cyc("decode", mk(0,0,0,0,0,0,(op == 7'b1101111) ? 3 : 2,1,1,0,0), rnd1(), 1'b0);
        case (op)
            7'b0000011: begin
                cyc("mem_adr", mk(0,0,0,0,0,0,0,2,1,0,0), rnd1(), 1'b0);
                mem_phase("mem_read", mk(1,0,1,0,0,0,0,0,0,0,0), mk(1,0,1,0,0,0,0,0,0,0,0), mw, to);
                if (to) trap_phase(2'b10);
                else cyc("mem_wb", mk(0,0,0,0,0,1,0,0,0,0,1), rnd1(), 1'b0);
            end
            7'b0100011: begin
                cyc("mem_adr_s", mk(0,0,0,0,0,0,1,2,1,0,0), rnd1(), 1'b0);
                mem_phase("mem_write", mk(1,1,1,0,0,0,0,0,0,0,0), mk(1,1,1,0,0,0,0,0,0,0,0), mw, to);
                if (to) trap_phase(2'b10);
            end
            7'b0110011: begin
                cyc("exec_r", mk(0,0,0,0,0,0,0,2,0,exp_alu(f3, ins[30]),0), rnd1(), 1'b0);
                cyc("alu_wb", mk(0,0,0,0,0,1,0,0,0,0,0), rnd1(), 1'b0);
            end
            7'b0010011: begin
                cyc("exec_i", mk(0,0,0,0,0,0,0,2,1,exp_alu(f3, ins[30] && f3 == 3'd5),0), rnd1(), 1'b0);
                cyc("alu_wb", mk(0,0,0,0,0,1,0,0,0,0,0), rnd1(), 1'b0);
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    cyc("branch_bad", mk(0,0,0,0,0,0,0,2,0,1,0), rnd1(), 1'b0);
                    trap_phase(2'b01);
                end else begin
                    // f3[2:1] picks the flag (00 zero, 10 lt, 11 ltu), f3[0] inverts it
                    flag = (f3[2:1] == 2'b00) ? z : (f3[1] ? lu : l);
                    cyc("branch", mk(0,0,0,0,int'(flag ^ f3[0]),0,0,2,0,1,0), rnd1(), 1'b0);
                end
            end
            7'b1101111: begin
                cyc("jal", mk(0,0,0,0,1,0,0,0,0,0,0), rnd1(), 1'b0);
                cyc("link", mk(0,0,0,0,0,1,0,1,2,0,2), rnd1(), 1'b0);
            end
            7'b1100111: begin
                cyc("jalr", mk(0,0,0,0,1,0,0,2,1,0,2), rnd1(), 1'b0);
                cyc("link", mk(0,0,0,0,0,1,0,1,2,0,2), rnd1(), 1'b0);
            end
            7'b0110111: cyc("lui", mk(0,0,0,0,0,1,4,0,0,0,3), rnd1(), 1'b0);
            default:    trap_phase(2'b01);
        endcase
    endtask

    // Store interrupted by reset while waiting on memory.
    // held: reset held for a cycle; otherwise a short pulse inside the next cycle.
    task automatic abort_store(input bit held);
        bit to;
        cur_instr = $urandom;
        mem_phase("fetch", mk(1,0,0,0,0,0,0,0,2,0,2), mk(1,0,0,1,1,0,0,0,2,0,2), 0, to);
        cur_instr = 32'h0030A023;
        cyc("decode", mk(0,0,0,0,0,0,2,1,1,0,0), rnd1(), 1'b0);
        cyc("mem_adr_s", mk(0,0,0,0,0,0,1,2,1,0,0), rnd1(), 1'b0);
        cyc("mem_write", mk(1,1,1,0,0,0,0,0,0,0,0), 1'b0, 1'b0);
        cyc("mem_write", mk(1,1,1,0,0,0,0,0,0,0,0), 1'b0, 1'b0);
        if (held) cyc("abort_reset", '0, 1'b0, 1'b1);
        else pulse_pending = 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  legal [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        logic [31:0] ins;
        logic [6:0]  op;
        bit          hit;
        int          k;
        ins = $urandom;
        k = $urandom_range(0, 9);
        if (k < 8) begin
            ins[6:0] = legal[k];
        end else begin
            for (int tries = 0; tries < 64; tries++) begin
                op = 7'($urandom);
                hit = 0;
                foreach (legal[j]) if (legal[j] == op) hit = 1;
                if (!hit) break;
            end
            ins[6:0] = hit ? 7'h7F : op;
        end
        return ins;
    endfunction

    function automatic int rand_waits();
        int r;
        r = $urandom_range(0, 39);
        if (r < 30) return $urandom_range(0, 2);
        if (r < 38) return $urandom_range(TIMEOUT - 1, TIMEOUT);
        return TIMEOUT + 1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.instr = '0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        bus.lt = 1'b0;
        bus.ltu = 1'b0;
        cur_instr = '0;
        cur_z = 1'b0;
        cur_l = 1'b0;
        cur_lu = 1'b0;

        // In reset every output is low, even with mem_ready high
        cyc("reset", '0, 1'b1, 1'b1);
        cyc("reset", '0, 1'b1, 1'b1);

        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);            // add x3,x1,x2
        run_instr(32'h0000A183, 0, 3, 1'b0, 1'b0, 1'b0);            // lw, 3 wait cycles
        run_instr(32'h0030A023, 1, 2, 1'b0, 1'b0, 1'b0);            // sw, 2 wait cycles
        run_instr(32'h0020D063, 0, 0, 1'b0, 1'b0, 1'b0);            // bge, lt=0 taken
        run_instr(32'h0020D063, 0, 0, 1'b1, 1'b1, 1'b0);            // bge, lt=1 not taken
        run_instr(32'h0020E063, 0, 0, 1'b0, 1'b0, 1'b1);            // bltu, ltu=1 taken
        run_instr(32'h0020A063, 0, 0, 1'b0, 1'b0, 1'b0);            // branch funct3 010 -> trap
        run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, 1'b0);            // jalr x1,0(x1)
        run_instr(32'h123452B7, TIMEOUT, 0, 1'b0, 1'b0, 1'b0);      // lui, ready exactly at limit
        run_instr(32'h002081B3, TIMEOUT + 5, 0, 1'b0, 1'b0, 1'b0);  // fetch timeout trap
        run_instr(32'h0000A183, 0, TIMEOUT + 1, 1'b0, 1'b0, 1'b0);  // load timeout trap
        run_instr(32'h0030A023, 0, TIMEOUT, 1'b0, 1'b0, 1'b0);      // store, ready at limit
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b0);            // illegal opcode
        abort_store(1'b1);
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        abort_store(1'b0);
        run_instr(32'h4020D1B3, 0, 0, 1'b0, 1'b0, 1'b0);            // sra after pulse reset

        for (int i = 0; i < 250; i++) begin
            if (i % 60 == 59) begin
                abort_store(1'($urandom_range(0, 1)));
            end
            run_instr(rand_instr(), rand_waits(), rand_waits(),
                      rnd1(), rnd1(), rnd1());
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle RV32I controller FSM, successor to the single-cycle control unit. Sequences each instruction over several cycles on a shared instruction/data memory. Adds a mem_req/mem_ready wait-state handshake, a bounded memory timeout, all six branch conditions, JALR and LUI, and a sticky trap state. Drives the multi-cycle datapath registers: PC, OldPC, IR, Data, ALUOut.

Parameters:
TIMEOUT, 15, maximum consecutive cycles a memory access may wait with mem_ready low before trapping (1..255)
TIMEOUT_EN, 1, 1 enables the timeout trap; 0 waits indefinitely

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
instr  input  32  IR contents; valid from DECODE onward
zero  input  1  ALU result == 0
lt  input  1  signed rs1 < rs2, from ALU subtract
ltu  input  1  unsigned rs1 < rs2
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
Mem_Write  output  1  access is a write
Adr_src  output  1  0 = PC, 1 = Result
IR_write  output  1  load IR (and OldPC)
PC_write  output  1  load PC from Result
Reg_write  output  1  register-file write enable
Imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
ALU_src_A  output  2  00 PC, 01 OldPC, 10 rd1
ALU_src_B  output  2  00 rd2, 01 imm, 10 constant 4
ALU_control  output  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
Result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
trap  output  1  FSM is in TRAP
trap_cause  output  2  00 none, 01 illegal instruction, 10 memory timeout

Behaviour:
- Reset: state = FETCH, wait counter = 0, trap_cause = 00. While in reset every output is 0. Reset mid-access drops mem_req immediately and aborts the access.
- Outputs are Moore (decoded from state) except PC_write, IR_write and Reg_write where noted. Every unlisted output is 0.
- FETCH: mem_req = 1, Adr_src = 0, A = 00, B = 10, add, Result_src = 10. When mem_ready: IR_write = 1, PC_write = 1, next state DECODE. Otherwise stay in FETCH.
- DECODE: A = 01, B = 01, add (ALUOut = branch/jump target). Imm_src = 011 if opcode 1101111, else 010. Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode -> TRAP, cause 01
- MEM_ADR: A = 10, B = 01, add, Imm_src = 001 if instr[5] else 000. Next: MEM_WRITE if instr[5], else MEM_READ.
- MEM_READ: mem_req = 1, Adr_src = 1, Result_src = 00. On mem_ready -> MEM_WB.
- MEM_WB: Result_src = 01, Reg_write = 1, next FETCH.
- MEM_WRITE: mem_req = 1, Mem_Write = 1, Adr_src = 1, Result_src = 00. Both requests are held stable until mem_ready. On mem_ready -> FETCH.
- EXEC_R: A = 10, B = 00, ALU op from funct3 and funct7[5]:
  - 000 -> add, or sub when funct7[5] = 1
  - 001 sll, 010 slt, 011 sltu, 100 xor
  - 101 -> srl, or sra when funct7[5] = 1
  - 110 or, 111 and
  - Next ALU_WB.
- EXEC_I: A = 10, B = 01, Imm_src = 000. Same decode as EXEC_R except funct3 000 is always add; funct7[5] is honoured only for funct3 101. Next ALU_WB.
- ALU_WB: Result_src = 00, Reg_write = 1, next FETCH.
- BRANCH: A = 10, B = 00, sub, Result_src = 00. PC_write = taken, where taken by funct3 is:
  - 000 zero, 001 !zero
  - 100 lt, 101 !lt
  - 110 ltu, 111 !ltu
  - Next FETCH. funct3 010 or 011 -> TRAP, cause 01, with PC_write = 0.
- JAL: Result_src = 00, PC_write = 1, next LINK.
- JALR: A = 10, B = 01, Imm_src = 000, add, Result_src = 10, PC_write = 1, next LINK. Target LSB clearing is the datapath's responsibility.
- LINK: A = 01, B = 10, add, Result_src = 10, Reg_write = 1, next FETCH. Writes OldPC + 4, so the link is correct when rd = rs1.
- LUI: Imm_src = 100, Result_src = 11, Reg_write = 1, next FETCH.
- Timeout counter (only in FETCH, MEM_READ, MEM_WRITE):
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - Clears on any state change.
  - When TIMEOUT_EN = 1 and the counter equals TIMEOUT with mem_ready still 0 -> TRAP, cause 10.
  - mem_ready in the same cycle as the limit wins: normal completion.
- TRAP: trap = 1, all control outputs 0, sticky until reset. trap_cause holds its value until reset.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; ALU_control = 0 in EXEC_R; Reg_write = 1 only in ALU_WB; 4 cycles total.
- lw (0x0000A183) with mem_ready low 3 cycles in MEM_READ -> mem_req and Adr_src held 4 cycles, Reg_write in MEM_WB; sw (0x0030A023) -> Mem_Write = 1 held until mem_ready.
- bge with lt = 0, then lt = 1 -> PC_write = 1, then 0, in BRANCH; bltu with ltu = 1 -> PC_write = 1; funct3 = 010 -> trap = 1, trap_cause = 01.
- jalr x1,0(x1) -> JALR: PC_write = 1, Result_src = 10; LINK: A = 01, B = 10, Reg_write = 1; next FETCH.
- TIMEOUT = 15, mem_ready held 0 in FETCH -> trap asserted after 15 wait cycles with cause 10; stays set; reset -> FETCH, trap = 0.
- Opcode 0x7F -> TRAP after DECODE with cause 01; reset asserted mid-MEM_WRITE -> mem_req and Mem_Write drop asynchronously, FSM restarts in FETCH.
